// File: rtl/ls_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, memory depth.
package ls_pkg;
  localparam int LS_MEM_WORDS = 256;
  localparam int LS_LANES     = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } ls_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } ls_state_e;
endpackage

// File: rtl/ls_align.sv
// Byte-lane merge for sub-word stores and extract/extend for loads (little-endian).
module ls_align
  import ls_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] merged,
  output logic [31:0] ldata
);
  logic [LS_LANES-1:0][7:0] rb, wb, mb;
  logic [LS_LANES-1:0]      be;
  logic [31:0]              sh;

  assign rb = rword;

  always_comb begin
    be = '1;
    case (size)
      SZ_BYTE: be = LS_LANES'(1) << lane;
      SZ_HALF: be = LS_LANES'(3) << lane;
      default: be = '1;
    endcase
  end

  // Right-aligned store data is replicated so each lane picks its own byte.
  for (genvar i = 0; i < LS_LANES; i++) begin : g_lane
    assign wb[i] = (size == SZ_BYTE) ? wdata[7:0] :
                   (size == SZ_HALF) ? wdata[8*(i%2) +: 8] :
                                       wdata[8*i +: 8];
    assign mb[i] = be[i] ? wb[i] : rb[i];
  end

  assign merged = mb;
  assign sh     = rword >> {lane, 3'b000};

  always_comb begin
    ldata = rword;
    case (size)
      SZ_BYTE: ldata = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: ldata = {{16{sgn & sh[15]}}, sh[15:0]};
      default: ldata = rword;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-port load/store unit: word stores write directly, sub-word stores
// do a read-modify-write, loads read and extend; one outstanding request.
module load_store_unit
  import ls_pkg::*;
#(
  parameter int MEM_WORDS = LS_MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ewr,
  output logic [31:0] mem_dir,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);
  ls_state_e   state;
  logic        r_we, r_sgn;
  logic [1:0]  r_size, r_lane;
  logic [31:0] r_wdata;
  logic        acc_err;
  logic [31:0] merged, ldata;

  always_comb begin
    acc_err = 1'b0;
    case (req_size)
      SZ_HALF: acc_err = req_addr[0];
      SZ_WORD: acc_err = |req_addr[1:0];
      SZ_RSVD: acc_err = 1'b1;
      default: acc_err = 1'b0;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) acc_err = 1'b1;
  end

  ls_align u_align (
    .size   (r_size),
    .lane   (r_lane),
    .sgn    (r_sgn),
    .wdata  (r_wdata),
    .rword  (mem_dout),
    .merged (merged),
    .ldata  (ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_ewr    <= 1'b0;
      mem_dir    <= '0;
      mem_din    <= '0;
      r_we       <= 1'b0;
      r_sgn      <= 1'b0;
      r_size     <= '0;
      r_lane     <= '0;
      r_wdata    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid && req_ready) begin
          r_we      <= req_we;
          r_sgn     <= req_signed;
          r_size    <= req_size;
          r_lane    <= req_addr[1:0];
          r_wdata   <= req_wdata;
          req_ready <= 1'b0;
          if (acc_err) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            mem_dir <= {2'b00, req_addr[31:2]};
            if (req_we && req_size == SZ_WORD) begin
              state   <= WR;
              mem_ewr <= 1'b1;
              mem_din <= req_wdata;
            end else begin
              state <= RD;
            end
          end
        end
        RD: if (r_we) begin
          state   <= WR;
          mem_ewr <= 1'b1;
          mem_din <= merged;
        end else begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= ldata;
          mem_dir    <= '0;
        end
        WR: begin
          state      <= RESP;
          mem_ewr    <= 1'b0;
          mem_dir    <= '0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL provide parameter MEM_WORDS, default 256, meaning data-memory depth in 32-bit words.
REQ-002 SHALL provide `clk` as an input, width 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL provide `rst_n` as an input, width 1, meaning the asynchronous, active-low reset.
REQ-004 SHALL provide `req_valid` as an input, width 1, meaning that a request is offered.
REQ-005 SHALL provide `req_ready` as an output, width 1, meaning that the unit can accept a request this cycle.
REQ-006 SHALL provide `req_we` as an input, width 1: 1 = store, 0 = load.
REQ-007 SHALL provide `req_size` as an input, width 2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-008 SHALL provide `req_signed` as an input, width 1, meaning sign-extend a sub-word load.
REQ-009 SHALL provide `req_addr` as an input, width 32, meaning the byte address.
REQ-010 SHALL provide `req_wdata` as an input, width 32, meaning store data, right-aligned for sub-word stores.
REQ-011 SHALL provide `resp_valid` as an output, width 1, meaning a one-cycle completion pulse.
REQ-012 SHALL provide `resp_rdata` as an output, width 32, meaning load result, which is 0 for stores and errors.
REQ-013 SHALL provide `resp_err` as an output, width 1, meaning misaligned, out-of-range or reserved-size request; it is valid with `resp_valid`.
REQ-014 SHALL provide `mem_ewr` as an output, width 1, meaning the data-memory write enable (level-sensitive memory).
REQ-015 SHALL provide `mem_dir` as an output, width 32, meaning the data-memory word index.
REQ-016 SHALL provide `mem_din` as an output, width 32, meaning the data-memory write word.
REQ-017 SHALL provide `mem_dout` as an input, width 32, meaning the data-memory read word, which is combinational from `mem_dir`.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR and RESP.
REQ-019 SHALL assert `req_ready` only in IDLE; a request is accepted on an edge where `req_valid` and `req_ready` are both 1.
REQ-020 SHALL latch all `req_*` fields at acceptance; later input changes have no effect until the next acceptance.
REQ-021 SHALL flag an error when `req_size` is 11, when half is used with `addr[0]` = 1, when word is used with `addr[1:0]` ≠ 0, or when `addr[31:2]` ≥ MEM_WORDS.
REQ-022 SHALL route transitions from IDLE as follows:
- error → RESP, with no memory access;
- load → RD;
- word store → WR;
- byte/half store → RD.
REQ-023 SHALL route transitions from RD as follows: load → RESP, capturing the extracted `mem_dout`; sub-word store → WR, capturing the merged word.
REQ-024 SHALL transition WR → RESP and RESP → IDLE unconditionally.
REQ-025 SHALL give the following latencies from the acceptance edge to the `resp_valid` cycle: error 1, word store 2, load 2, sub-word store 3.
REQ-026 SHALL drive `mem_dir` = `{0, addr[31:2]}` registered, stable throughout RD and WR, and 0 in IDLE.
REQ-027 SHALL drive `mem_ewr` = 1 only while in WR, from a registered source; it is 0 in all other states.
REQ-028 SHALL hold `mem_din` constant throughout WR.
REQ-029 SHALL perform a sub-word store as a read-modify-write: replace only the addressed byte lane(s) (little-endian, lane = `addr[1:0]`) and preserve the other lanes.
REQ-030 SHALL form a load result by taking the addressed byte/half and then zero-extending it, or sign-extending it when `req_signed` = 1; a word load is returned unchanged.
REQ-031 SHALL assert `resp_valid` for exactly one cycle in RESP; there is no response backpressure.
REQ-032 SHALL NOT accept a new request in the RESP cycle; the earliest next acceptance is the edge that leaves IDLE's first cycle.

Reset
REQ-033 SHALL, while `rst_n` = 0, asynchronously force: state IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0, `mem_ewr` = 0, `mem_dir` = 0, `mem_din` = 0.
REQ-034 SHALL drop `mem_ewr` immediately on a reset assertion during WR (the write may be partial), and SHALL produce no response for the aborted request.

Structure
REQ-035 SHALL place the size encodings, the FSM state enum and the MEM_WORDS default in shared package `ls_pkg`.
REQ-036 SHALL place the combinational lane merge (store) and extract/extend (load) logic in sub-module `ls_align`.

Verification
REQ-037 SHALL verify a word store followed by a load: store `addr` 0x10, data 0xDEADBEEF → `mem_ewr` pulse with `mem_dir` = 4; load 0x10 → `resp_rdata` = 0xDEADBEEF two cycles after acceptance.
REQ-038 SHALL verify byte read-modify-write: preload word 4 = 0x11223344; store byte 0xAA to 0x12 → word 4 = 0x11AA3344, with a response three cycles after acceptance.
REQ-039 SHALL verify extension: with word 4 = 0x11AA3344, a signed byte load from 0x12 → 0xFFFFFFAA, and an unsigned load → 0x000000AA.
REQ-040 SHALL verify errors: a half load from 0x13, a word store to 0x402 and `req_size` = 11 → `resp_err` = 1 one cycle after acceptance, with `mem_ewr` never asserted.
REQ-041 SHALL verify back-to-back requests: `req_valid` held high with two loads → the second is accepted only after RESP, and `req_ready` = 0 during RD and RESP.
REQ-042 SHALL verify reset during WR: `rst_n` low mid-WR → `mem_ewr` = 0 the same cycle, no `resp_valid` pulse, and `req_ready` = 1 after release.
